sequenciador_somador_ncl: RTL and testbench
===========================================

# sequenciador_somador_ncl

Synchronous controller that shares one dual-rail 4-bit ripple adder (`somador_4bits`) between two binary requesters. It arbitrates round-robin and encodes the granted operands to dual-rail. It then sequences a full NCL cycle (DATA wavefront, completion, NULL wavefront, null-completion) and returns the captured binary sum on a single response channel. It is the clocked boundary between the synchronous system and the self-timed adder.

## Interface
- `TIMEOUT_CICLOS`, 15: maximum cycles spent waiting in DATA or NULL phase before flagging an error; range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `req_valid`  in  2  request valid, one bit per requester.
- `req_ready`  out  2  grant/accept, one-hot or zero.
- `req_a0`, `req_b0`  in  4  binary operands, requester 0.
- `req_cin0`  in  1  carry-in, requester 0.
- `req_a1`, `req_b1`, `req_cin1`  in  4/4/1  same for requester 1.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  requester that issued the operation.
- `rsp_soma`  out  4  binary sum.
- `rsp_cout`  out  1  binary carry-out.
- `rsp_err`  out  1  timeout or illegal rail code during the operation.

## Operation
- Dual-rail code per bit: pair `[2i+1:2i]`. NULL=00, DATA0=01, DATA1=10, 11 illegal. Adder inputs are driven from registers only.
- States: OCIOSO, DADOS, NULO, RESPOSTA.
- OCIOSO: rails NULL. If any `req_valid` is set, assert `req_ready` combinationally for the granted requester. On that cycle, latch the encoded a/b/cin, latch `rsp_id`, and go to DADOS.
- Arbitration: if only one is valid, grant it. If both are valid, grant the one not granted last. The pointer updates on grant only and resets to "last=1", so requester 0 wins the first tie.
- DADOS: rails hold the DATA word. When all 5 output pairs (soma[3:0], cout) are non-NULL and none is 11:
  - capture the decoded soma/cout;
  - go to NULO.
- Any 11 on an output pair in DADOS sets the sticky error and goes to NULO.
- Timer expiry in DADOS sets the error and goes to NULO; soma/cout are captured as 0.
- NULO: rails NULL. When all 10 output rails are 0, go to RESPOSTA. Timer expiry sets the error and goes to RESPOSTA.
- RESPOSTA: `rsp_valid`=1 with stable id/soma/cout/err. On `rsp_valid && rsp_ready`, go to OCIOSO and clear the error flag. No new request is accepted in RESPOSTA.
- Timer: cleared on every state entry, incremented each cycle in DADOS/NULO. Expiry occurs when the count equals `TIMEOUT_CICLOS`.
- Arithmetic: `{rsp_cout,rsp_soma}` = a+b+cin, 5 bits, no overflow flag.

## Timing
- Reset values:
  - state OCIOSO;
  - all adder rails 0 (NULL);
  - `req_ready`=0 while `rst`=1;
  - `rsp_valid`/`rsp_id`/`rsp_soma`/`rsp_cout`/`rsp_err`=0;
  - timer 0;
  - arbitration pointer=1.
- Nominal latency with the combinational adder (accept at cycle T):
  - DADOS in T+1; completion seen in T+1;
  - NULO in T+2;
  - RESPOSTA, `rsp_valid`=1, in T+3.
- With `rsp_ready` held high, the response completes at T+3, OCIOSO is entered at T+4, and the next accept can happen at T+4. Peak throughput is one operation per 4 cycles.
- `rsp_*` holds stable while `rsp_valid && !rsp_ready`; backpressure is unbounded.
- Reset mid-operation: next cycle is OCIOSO with NULL rails; the in-flight operation is dropped with no response.
- Requests deasserted before grant are never accepted. Operands are sampled only on the accept cycle.

## Structure
- Package `pacote_ncl`: rail constants NULO/DADO0/DADO1, state enum, function `codifica_dr(bin)` → dual-rail, and function `decodifica_dr(dr)` → binary.
- Sub-module `detector_completude` (parameter N pairs): outputs `completo` (all pairs valid), `nulo` (all rails 0) and `ilegal` (any pair 11). It is instantiated once over the 5 output pairs.
- `somador_4bits` is instantiated inside the sequencer.

## Test plan
- Reset, then single request r0 a=5, b=3, cin=0: `req_ready`=01 at T, `rsp_valid` at T+3 with soma=8, cout=0, id=0, err=0.
- r1 a=15, b=15, cin=1 → soma=15, cout=1, id=1.
- Both valid continuously with `rsp_ready`=1: grants alternate 0,1,0,1, four cycles apart.
- `rsp_ready`=0 for 10 cycles: response held stable, no `req_ready` asserted, and the response completes when `rsp_ready` rises.
- Force one adder output pair to 11 during DADOS → `rsp_err`=1; force cout rails stuck 00 → timeout after 15 cycles, `rsp_err`=1, soma=0, cout=0.
- Assert `rst` in NULO → next cycle rails 0, `rsp_valid`=0, pointer=1; a subsequent tie grants r0.

Source files
------------

// File: rtl/pacote_ncl.sv
// Shared definitions for the NCL adder sequencer: rail codes, FSM states and
// binary <-> dual-rail conversion helpers.
package pacote_ncl;

  localparam logic [1:0] NULO   = 2'b00;
  localparam logic [1:0] DADO0  = 2'b01;
  localparam logic [1:0] DADO1  = 2'b10;
  localparam logic [1:0] ILEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_OCIOSO,
    ST_DADOS,
    ST_NULO,
    ST_RESPOSTA
  } estado_t;

  function automatic logic [1:0] codifica_bit(input logic bin);
    return bin ? DADO1 : DADO0;
  endfunction

  function automatic logic [7:0] codifica_dr(input logic [3:0] bin);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2*i +: 2] = codifica_bit(bin[i]);
    return r;
  endfunction

  // Decodes the 5 adder output pairs {cout, soma[3:0]}; the true rail carries the value.
  function automatic logic [4:0] decodifica_dr(input logic [9:0] dr);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r[i] = (dr[2*i +: 2] == DADO1);
    return r;
  endfunction

endpackage

// File: rtl/detector_completude.sv
// Completion detector over N dual-rail pairs: all-valid, all-null and any-illegal.
module detector_completude
  import pacote_ncl::*;
#(
  parameter int N = 5
) (
  input  logic [2*N-1:0] i_dr,
  output logic           o_completo,
  output logic           o_nulo,
  output logic           o_ilegal
);

  always_comb begin
    o_completo = 1'b1;
    o_ilegal   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_dr[2*i +: 2] == NULO || i_dr[2*i +: 2] == ILEGAL) o_completo = 1'b0;
      if (i_dr[2*i +: 2] == ILEGAL) o_ilegal = 1'b1;
    end
  end

  assign o_nulo = (i_dr == '0);

endmodule

// File: rtl/somador_4bits.sv
// Dual-rail 4-bit ripple adder; every output pair stays NULL until all of its inputs are DATA.
module somador_4bits (
  input  logic [7:0] i_a_dr,
  input  logic [7:0] i_b_dr,
  input  logic [1:0] i_cin_dr,
  output logic [7:0] o_soma_dr,
  output logic [1:0] o_cout_dr
);

  // Returns {soma1, soma0, carry1, carry0}; only full minterms, so NULL inputs give NULL outputs.
  function automatic logic [3:0] celula(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c);
    logic s1, s0, c1, c0;
    s1 = (a[1] & b[1] & c[1]) | (a[1] & b[0] & c[0]) | (a[0] & b[1] & c[0]) | (a[0] & b[0] & c[1]);
    s0 = (a[0] & b[0] & c[0]) | (a[0] & b[1] & c[1]) | (a[1] & b[0] & c[1]) | (a[1] & b[1] & c[0]);
    c1 = (a[1] & b[1] & c[0]) | (a[1] & b[1] & c[1]) | (a[1] & b[0] & c[1]) | (a[0] & b[1] & c[1]);
    c0 = (a[0] & b[0] & c[0]) | (a[0] & b[0] & c[1]) | (a[0] & b[1] & c[0]) | (a[1] & b[0] & c[0]);
    return {s1, s0, c1, c0};
  endfunction

  logic [9:0] w_c;
  logic [3:0] w_cel;

  always_comb begin
    w_c       = '0;
    w_cel     = '0;
    o_soma_dr = '0;
    w_c[1:0]  = i_cin_dr;
    for (int i = 0; i < 4; i++) begin
      w_cel               = celula(i_a_dr[2*i +: 2], i_b_dr[2*i +: 2], w_c[2*i +: 2]);
      o_soma_dr[2*i +: 2] = w_cel[3:2];
      w_c[2*i+2 +: 2]     = w_cel[1:0];
    end
    o_cout_dr = w_c[9:8];
  end

endmodule

// File: rtl/sequenciador_somador_ncl.sv
// Clocked front end for the self-timed adder: round-robin arbitration, NCL DATA/NULL
// sequencing with timeout, and a single valid/ready response channel.
module sequenciador_somador_ncl
  import pacote_ncl::*;
#(
  parameter int TIMEOUT_CICLOS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_a0,
  input  logic [3:0] req_b0,
  input  logic       req_cin0,
  input  logic [3:0] req_a1,
  input  logic [3:0] req_b1,
  input  logic       req_cin1,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_soma,
  output logic       rsp_cout,
  output logic       rsp_err
);

  localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS);

  estado_t    r_estado;
  logic [7:0] r_a_dr, r_b_dr;
  logic [1:0] r_cin_dr;
  logic [7:0] r_timer;
  logic       r_ultimo;
  logic       r_valid, r_id, r_cout, r_err;
  logic [3:0] r_soma;

  logic [1:0] w_grant;
  logic       w_aceita, w_sel, w_cin_sel;
  logic [3:0] w_a_sel, w_b_sel;
  logic [7:0] w_soma_dr;
  logic [1:0] w_cout_dr;
  logic [9:0] w_saida_dr;
  logic [4:0] w_saida_bin;
  logic       w_completo, w_nulo, w_ilegal, w_expirou;

  // On a tie the requester not granted last wins.
  always_comb begin
    w_grant = 2'b00;
    case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_ultimo ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  assign req_ready = (r_estado == ST_OCIOSO && !rst) ? w_grant : 2'b00;
  assign w_aceita  = |req_ready;
  assign w_sel     = req_ready[1];
  assign w_a_sel   = w_sel ? req_a1 : req_a0;
  assign w_b_sel   = w_sel ? req_b1 : req_b0;
  assign w_cin_sel = w_sel ? req_cin1 : req_cin0;

  somador_4bits u_somador (
    .i_a_dr   (r_a_dr),
    .i_b_dr   (r_b_dr),
    .i_cin_dr (r_cin_dr),
    .o_soma_dr(w_soma_dr),
    .o_cout_dr(w_cout_dr)
  );

  assign w_saida_dr  = {w_cout_dr, w_soma_dr};
  assign w_saida_bin = decodifica_dr(w_saida_dr);
  assign w_expirou   = (r_timer == LIMITE);

  detector_completude #(.N(5)) u_detector (
    .i_dr      (w_saida_dr),
    .o_completo(w_completo),
    .o_nulo    (w_nulo),
    .o_ilegal  (w_ilegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= ST_OCIOSO;
      r_a_dr   <= '0;
      r_b_dr   <= '0;
      r_cin_dr <= NULO;
      r_timer  <= '0;
      r_ultimo <= 1'b1;
      r_valid  <= 1'b0;
      r_id     <= 1'b0;
      r_soma   <= '0;
      r_cout   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_estado)
        ST_OCIOSO: begin
          if (w_aceita) begin
            r_a_dr   <= codifica_dr(w_a_sel);
            r_b_dr   <= codifica_dr(w_b_sel);
            r_cin_dr <= codifica_bit(w_cin_sel);
            r_id     <= w_sel;
            r_ultimo <= w_sel;
            r_soma   <= '0;
            r_cout   <= 1'b0;
            r_err    <= 1'b0;
            r_timer  <= '0;
            r_estado <= ST_DADOS;
          end
        end
        ST_DADOS: begin
          if (w_ilegal || w_completo || w_expirou) begin
            r_a_dr   <= '0;
            r_b_dr   <= '0;
            r_cin_dr <= NULO;
            r_timer  <= '0;
            r_estado <= ST_NULO;
            if (w_ilegal || !w_completo) r_err <= 1'b1;
            if (!w_ilegal && w_completo) begin
              r_soma <= w_saida_bin[3:0];
              r_cout <= w_saida_bin[4];
            end
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_NULO: begin
          if (w_nulo || w_expirou) begin
            if (!w_nulo) r_err <= 1'b1;
            r_timer  <= '0;
            r_valid  <= 1'b1;
            r_estado <= ST_RESPOSTA;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        ST_RESPOSTA: begin
          if (rsp_ready) begin
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_timer  <= '0;
            r_estado <= ST_OCIOSO;
          end
        end
        default: r_estado <= ST_OCIOSO;
      endcase
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_soma  = r_soma;
  assign rsp_cout  = r_cout;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_sequenciador_somador_ncl.sv
// Directed bench: table of single operations plus arbitration, backpressure,
// fault-injection and mid-operation reset sequences.
module tb_sequenciador_somador_ncl;
  import pacote_ncl::*;

  logic       clk, rst;
  logic [1:0] req_valid, req_ready;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic       req_cin0, req_cin1;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_err;
  logic [3:0] rsp_soma;

  int checks = 0;
  int errors = 0;

  sequenciador_somador_ncl #(.TIMEOUT_CICLOS(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_soma(rsp_soma), .rsp_cout(rsp_cout), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [3:0] a0, b0;
    logic       cin0;
    logic [3:0] a1, b1;
    logic       cin1;
    logic       id;
    logic [3:0] soma;
    logic       cout;
  } vec_t;

  vec_t tab[7];

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  // Called at a negedge in OCIOSO; returns at the negedge after the accept edge.
  task automatic aplica(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                        input logic c0, input logic [3:0] a1, input logic [3:0] b1,
                        input logic c1, input logic [1:0] exp_ready, input string nome);
    req_valid = v; req_a0 = a0; req_b0 = b0; req_cin0 = c0;
    req_a1 = a1; req_b1 = b1; req_cin1 = c1;
    #1;
    check({nome, "_ready"}, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  // n = cycles after the accept cycle until rsp_valid is seen.
  task automatic espera_rsp(output int n, input string nome);
    n = 1;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no rsp_valid expected rsp_valid within 60 cycles", nome);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  int n;
  int g_ciclo[$];
  int g_id[$];

  initial begin
    tab[0] = '{2'b01, 4'd5,  4'd3, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd8,  1'b0};
    tab[1] = '{2'b10, 4'd0,  4'd0, 1'b0, 4'd15, 4'd15, 1'b1, 1'b1, 4'd15, 1'b1};
    tab[2] = '{2'b11, 4'd7,  4'd9, 1'b1, 4'd2,  4'd2,  1'b0, 1'b0, 4'd1,  1'b1};
    tab[3] = '{2'b11, 4'd0,  4'd0, 1'b0, 4'd8,  4'd7,  1'b0, 1'b1, 4'd15, 1'b0};
    tab[4] = '{2'b10, 4'd3,  4'd3, 1'b0, 4'd0,  4'd0,  1'b1, 1'b1, 4'd1,  1'b0};
    tab[5] = '{2'b11, 4'd10, 4'd6, 1'b0, 4'd1,  4'd1,  1'b1, 1'b0, 4'd0,  1'b1};
    tab[6] = '{2'b01, 4'd4,  4'd4, 1'b1, 4'd9,  4'd9,  1'b1, 1'b0, 4'd9,  1'b0};

    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_a0 = '0; req_b0 = '0; req_cin0 = 1'b0; req_a1 = '0; req_b1 = '0; req_cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_outs", 32'({rsp_id, rsp_soma, rsp_cout, rsp_err}), 32'd0);
    check("reset_rails", 32'({dut.r_a_dr, dut.r_b_dr, dut.r_cin_dr}), 32'd0);
    rst = 1'b0; req_valid = 2'b00;

    for (int i = 0; i < 7; i++) begin
      aplica(tab[i].valid, tab[i].a0, tab[i].b0, tab[i].cin0, tab[i].a1, tab[i].b1, tab[i].cin1,
             tab[i].id ? 2'b10 : 2'b01, $sformatf("vec%0d", i));
      espera_rsp(n, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
      check($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(tab[i].id));
      check($sformatf("vec%0d_sum", i), 32'({rsp_cout, rsp_soma}), 32'({tab[i].cout, tab[i].soma}));
      check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'd0);
      handshake();
    end

    // Both requesters valid continuously: last grant went to r0, so r1 leads.
    req_valid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        g_ciclo.push_back(c);
        g_id.push_back(int'(req_ready[1]));
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    check("rr_count", 32'(g_ciclo.size()), 32'd4);
    if (g_ciclo.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_id%0d", k), 32'(g_id[k]), 32'((k % 2 == 0) ? 1 : 0));
        check($sformatf("rr_cycle%0d", k), 32'(g_ciclo[k]), 32'(4 * k));
      end
    end
    @(negedge clk);

    // Backpressure: response must hold for 10 cycles with no new grant.
    rsp_ready = 1'b0;
    aplica(2'b01, 4'd6, 4'd5, 1'b0, 4'd1, 4'd2, 1'b0, 2'b01, "bp");
    req_valid = 2'b11;
    espera_rsp(n, "bp");
    check("bp_latency", 32'(n), 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", c),
            32'({rsp_valid, rsp_id, rsp_cout, rsp_soma, rsp_err, req_ready}),
            32'({1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 2'b00}));
    end
    req_valid = 2'b00;
    handshake();
    check("bp_release", 32'(rsp_valid), 32'd0);

    // Illegal code on the carry pair during DADOS.
    force dut.w_cout_dr = 2'b11;
    aplica(2'b01, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, "ilegal");
    espera_rsp(n, "ilegal");
    check("ilegal_err", 32'(rsp_err), 32'd1);
    release dut.w_cout_dr;
    handshake();
    check("ilegal_err_cleared", 32'(rsp_err), 32'd0);

    // Carry rails stuck NULL: DADOS times out at count 15.
    force dut.w_cout_dr = 2'b00;
    aplica(2'b10, 4'd0, 4'd0, 1'b0, 4'd9, 4'd9, 1'b0, 2'b10, "stuck");
    espera_rsp(n, "stuck");
    check("stuck_latency", 32'(n), 32'd18);
    check("stuck_rsp", 32'({rsp_err, rsp_id, rsp_cout, rsp_soma}), 32'({1'b1, 1'b1, 1'b0, 4'd0}));
    release dut.w_cout_dr;
    handshake();

    // Reset while in NULO drops the operation and restores the pointer.
    aplica(2'b01, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0, 1'b0, 2'b01, "rstop");
    @(negedge clk);
    check("rstop_in_nulo", 32'(dut.r_estado), 32'(ST_NULO));
    rst = 1'b1; req_valid = 2'b11;
    req_a0 = 4'd2; req_b0 = 4'd9; req_cin0 = 1'b1; req_a1 = 4'd5; req_b1 = 4'd5; req_cin1 = 1'b0;
    #1;
    check("rstop_ready_in_rst", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstop_rails", 32'({dut.r_a_dr, dut.r_b_dr, dut.r_cin_dr}), 32'd0);
    check("rstop_valid", 32'(rsp_valid), 32'd0);
    check("rstop_ptr", 32'(dut.r_ultimo), 32'd1);
    check("rstop_state", 32'(dut.r_estado), 32'(ST_OCIOSO));
    rst = 1'b0;
    aplica(2'b11, 4'd2, 4'd9, 1'b1, 4'd5, 4'd5, 1'b0, 2'b01, "pos_rst");
    espera_rsp(n, "pos_rst");
    check("pos_rst_latency", 32'(n), 32'd3);
    check("pos_rst_rsp", 32'({rsp_id, rsp_cout, rsp_soma, rsp_err}), 32'({1'b0, 1'b0, 4'd12, 1'b0}));
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
